// File: rtl/c1541_head_ctrl_if.sv
// ---------------------------------------------------------------------------
// c1541_head_ctrl_if
// Signal bundle between the drive logic / SD track buffer and the head
// positioner.
//   master : drive side (stepper phases, motor, activity, buffer status);
//            observes head position, committed track and save requests.
//   slave  : head controller; consumes the drive inputs and produces
//            halftrack, track, track_valid, tr00_sense_n, save_track,
//            save_track_num and dirty.
// ---------------------------------------------------------------------------
interface c1541_head_ctrl_if;
    logic [1:0] stp;
    logic       mtr;
    logic       act;
    logic       buff_we;
    logic       disk_change;
    logic       busy;
    logic [6:0] halftrack;
    logic [5:0] track;
    logic       track_valid;
    logic       tr00_sense_n;
    logic       save_track;
    logic [5:0] save_track_num;
    logic       dirty;

    modport master (
        output stp, mtr, act, buff_we, disk_change, busy,
        input  halftrack, track, track_valid, tr00_sense_n,
               save_track, save_track_num, dirty
    );

    modport slave (
        input  stp, mtr, act, buff_we, disk_change, busy,
        output halftrack, track, track_valid, tr00_sense_n,
               save_track, save_track_num, dirty
    );
endinterface

// File: rtl/c1541_head_ctrl.sv
// ---------------------------------------------------------------------------
// c1541_head_ctrl
// Head positioner and track-commit controller for the 1541 drive.
// Decodes stepper phase changes into a half-track position, commits a new
// track once the head has settled and the SD buffer is idle, and tracks the
// dirty state of the loaded track, issuing one-cycle write-back requests.
// Ports:
//   clk32   : drive clock (32 MHz)
//   reset_n : synchronous active-low reset
//   bus     : c1541_head_ctrl_if.slave (stepper/motor/activity/buffer in,
//             head position, committed track and save request out)
// ---------------------------------------------------------------------------
module c1541_head_ctrl #(
    parameter logic [6:0]  MAX_HALFTRACK   = 7'd80,
    parameter logic [6:0]  START_HALFTRACK = 7'd36,
    parameter logic [16:0] SETTLE_CYCLES   = 17'd64000
) (
    input  logic               clk32,
    input  logic               reset_n,
    c1541_head_ctrl_if.slave   bus
);

    logic [6:0]  halftrack_q,      halftrack_d;
    logic [5:0]  track_q,          track_d;
    logic [1:0]  stp_q;
    logic [16:0] cnt_q,            cnt_d;
    logic        track_valid_q,    track_valid_d;
    logic        dirty_q,          dirty_d;
    logic        pend_q,           pend_d;
    logic        save_q,           save_d;
    logic [5:0]  save_num_q,       save_num_d;
    logic        mtr_q;
    logic        act_q;

    logic        step_in_s;
    logic        step_out_s;
    logic        step_s;
    logic        commit_s;
    logic        event_s;

    // Next-state decode: stepping, settle timer, commit and save/dirty tracking
    always_comb begin
        step_in_s  = bus.mtr && (bus.stp == (stp_q + 2'd1));
        step_out_s = bus.mtr && (bus.stp == (stp_q - 2'd1));
        // An outward step at half-track 0 is a head bump and changes nothing,
        // while an inward step at the limit still restarts the settle timer.
        step_s     = step_in_s || (step_out_s && (halftrack_q != 7'd0));

        halftrack_d = halftrack_q;
        if (step_in_s) begin
            if (halftrack_q != MAX_HALFTRACK) begin
                halftrack_d = halftrack_q + 7'd1;
            end else begin
                halftrack_d = halftrack_q;
            end
        end else if (step_out_s && (halftrack_q != 7'd0)) begin
            halftrack_d = halftrack_q - 7'd1;
        end else begin
            halftrack_d = halftrack_q;
        end

        cnt_d = cnt_q;
        if (step_s) begin
            cnt_d = SETTLE_CYCLES;
        end else if (cnt_q != 17'd0) begin
            cnt_d = cnt_q - 17'd1;
        end else begin
            cnt_d = 17'd0;
        end

        commit_s = (cnt_q == 17'd0) && !bus.busy && (halftrack_q[6:1] != track_q);
        track_d  = track_q;
        if (commit_s) begin
            track_d = halftrack_q[6:1];
        end else begin
            track_d = track_q;
        end

        track_valid_d = (cnt_d == 17'd0) && (halftrack_d[6:1] == track_d);

        event_s    = (act_q & ~bus.act) | (mtr_q & ~bus.mtr);
        save_d     = 1'b0;
        save_num_d = save_num_q;
        pend_d     = pend_q;
        dirty_d    = dirty_q;
        if (bus.disk_change) begin
            // A newly mounted image makes the loaded track meaningless.
            save_d  = 1'b0;
            pend_d  = 1'b0;
            dirty_d = 1'b0;
        end else if (!bus.busy && dirty_q && (commit_s || event_s || pend_q)) begin
            // On a commit the old track is still in track_q this cycle.
            save_d     = 1'b1;
            save_num_d = track_q;
            pend_d     = 1'b0;
            dirty_d    = bus.buff_we;
        end else begin
            if (bus.busy && dirty_q && event_s) begin
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
            dirty_d = dirty_q | bus.buff_we;
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            halftrack_q   <= START_HALFTRACK;
            track_q       <= START_HALFTRACK[6:1];
            stp_q         <= bus.stp;
            cnt_q         <= 17'd0;
            track_valid_q <= 1'b1;
            dirty_q       <= 1'b0;
            pend_q        <= 1'b0;
            save_q        <= 1'b0;
            save_num_q    <= 6'd0;
            mtr_q         <= bus.mtr;
            act_q         <= bus.act;
        end else begin
            halftrack_q   <= halftrack_d;
            track_q       <= track_d;
            stp_q         <= bus.stp;
            cnt_q         <= cnt_d;
            track_valid_q <= track_valid_d;
            dirty_q       <= dirty_d;
            pend_q        <= pend_d;
            save_q        <= save_d;
            save_num_q    <= save_num_d;
            mtr_q         <= bus.mtr;
            act_q         <= bus.act;
        end
    end

    assign bus.halftrack      = halftrack_q;
    assign bus.track          = track_q;
    assign bus.track_valid    = track_valid_q;
    assign bus.tr00_sense_n   = |halftrack_q[6:1];
    assign bus.save_track     = save_q;
    assign bus.save_track_num = save_num_q;
    assign bus.dirty          = dirty_q;

endmodule

// File: doc/c1541_head_ctrl.md
Name: c1541_head_ctrl

Overview:
- Drive-side head positioner and track-commit controller for the 1541 core, running on the drive clock.
- Sits between c1541_logic (stepper phases, motor, activity) and the SD track buffer (c1541_track / c1541_gcr).
- Decodes stepper phase changes into a half-track position and holds off track changes until the head has settled and the SD side is idle.
- Tracks dirty state of the loaded track and issues one-cycle write-back requests.

Parameters:
- MAX_HALFTRACK, 80, highest reachable half-track (7-bit).
- START_HALFTRACK, 36, half-track loaded at reset (track 18).
- SETTLE_CYCLES, 64000, clk32 cycles after the last step before a commit is allowed (2 ms at 32 MHz); must be ≥ 1, 17-bit counter.

Ports:
- clk32, in, 1, drive clock (32 MHz).
- reset_n, in, 1, synchronous active-low reset.
- stp, in, 2, stepper phase from c1541_logic.
- mtr, in, 1, spindle motor on.
- act, in, 1, drive activity LED/bit.
- buff_we, in, 1, GCR stage writes the track buffer.
- disk_change, in, 1, level; high while a new image is mounted.
- busy, in, 1, SD track buffer busy.
- halftrack, out, 7, physical head position.
- track, out, 6, committed track (0-40).
- track_valid, out, 1, high when track equals halftrack[6:1] and the head is settled.
- tr00_sense_n, out, 1, low when halftrack[6:1] == 0.
- save_track, out, 1, one-cycle write-back request.
- save_track_num, out, 6, track to write back, valid while save_track is high.
- dirty, out, 1, committed track modified since load or save.

Behaviour:
- Reset (reset_n == 0 on a clock edge): halftrack = START_HALFTRACK; track = START_HALFTRACK >> 1; stp_r = stp; settle counter = 0; track_valid = 1; dirty = 0; save_track = 0; save_track_num = 0.
  - A pending dirty track is discarded with no save.
  - mtr_r and act_r load their inputs.
- Step decode: stp_r is registered every cycle. Steps are accepted only when mtr == 1.
  - stp == stp_r + 1 (mod 4): inward step; halftrack + 1, saturating at MAX_HALFTRACK.
  - stp == stp_r − 1 (mod 4): outward step; halftrack − 1; at 0 the step is ignored (head bump).
  - Difference of 2 or 0: no movement.
  - Any accepted step (including a saturated one) reloads the settle counter to SETTLE_CYCLES and forces track_valid = 0 on the next cycle.
- Settle counter: decrements by 1 per cycle while non-zero.
- Commit: in a cycle where counter == 0 and busy == 0 and halftrack[6:1] != track:
  - track <= halftrack[6:1], one-cycle latency.
  - If dirty, save_track pulses in that same cycle with save_track_num = old track, and dirty clears.
  - While busy == 1 the commit waits indefinitely.
- track_valid = (counter == 0) && (halftrack[6:1] == track), registered.
- Other save events, each evaluated only when dirty == 1 and busy == 0:
  - act falling edge (act_r & ~act).
  - mtr falling edge.
  - If the event occurs while busy == 1, it is held as pending and issued on the first cycle with busy == 0, provided dirty is still 1.
  - Only one save_track pulse per cycle. save_track_num = track (the committed track).
- Dirty:
  - buff_we sets dirty. buff_we wins over a same-cycle save clear, so a save pulse is still issued and dirty stays 1.
  - disk_change == 1 clears dirty and any pending save with no pulse, and has priority over buff_we.
- Minimum save_track spacing is 1 cycle. A saved track re-dirtied by buff_we is saved again on the next event.
- tr00_sense_n = |halftrack[6:1], combinational from the register.
- Motor off: halftrack frozen. The settle counter keeps running, and a commit may still complete.

Test Plan:
- Reset with stp = 0 -> halftrack = 36, track = 18, track_valid = 1, dirty = 0, save_track = 0, tr00_sense_n = 1.
- mtr = 1, stp 0→1→2 (one change every 10 cycles), busy = 0 -> halftrack 38; track_valid low for SETTLE_CYCLES after the last step; then track = 19, track_valid = 1; no save_track pulse.
- buff_we pulse at track 18, then two inward steps -> at commit, save_track pulses for exactly 1 cycle with save_track_num = 18, track = 19, dirty = 0.
- Commit pending with busy held high for 500 cycles -> track unchanged until busy falls; commit and save occur on the first cycle with busy == 0.
- 90 outward steps from reset -> halftrack saturates at 0, tr00_sense_n = 0, track = 0 after settle; then 100 inward steps -> halftrack = 80, track = 40.
- dirty set, then act falls in the same cycle as disk_change = 1 -> no save_track pulse, dirty = 0. Repeat with disk_change = 0 -> save_track_num = current track.
